reset_sequencer: RTL and testbench

Staged reset controller that drives ordered active-low resets into N downstream domains. All stage resets assert together and are held for a minimum number of enabled ticks. Stages are then released one at a time. Each release waits for that stage's ready acknowledge, followed by an inter-stage gap. The block sits between the board/soft reset sources and the per-subsystem reset inputs, and reports completion, busy and timeout status.

---
 rtl/reset_sequencer.sv | 167 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset controller.
//
// Holds every downstream active-low reset low for HOLD_CYCLES enabled ticks, then releases
// the stages one at a time in order 0..N_STAGES-1. After each release it waits for that
// stage's ready acknowledge (bounded by TIMEOUT enabled ticks), then waits STAGE_DELAY
// enabled ticks before releasing the next stage.
//
// Ports:
//   i_clk      clock
//   i_rstn     synchronous active-low reset
//   i_enb      tick enable; the shared counter only advances when high
//   i_req      soft reset request; behaves like i_rstn=0 and holds the counter at 0
//   i_ready    per-stage ready ack; only the current stage's bit is looked at
//   o_rstn     per-stage active-low resets, thermometer-coded from bit 0
//   o_busy     sequence in progress (holding, waiting for ready, or in a gap)
//   o_done     all stages released and acknowledged
//   o_timeout  a stage failed to acknowledge in time
module reset_sequencer #(
  parameter int unsigned N_STAGES    = 3,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_DELAY = 8,
  parameter int unsigned TIMEOUT     = 1023,
  parameter int unsigned CW          = 10
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_enb,
  input  logic                i_req,
  input  logic [N_STAGES-1:0] i_ready,
  output logic [N_STAGES-1:0] o_rstn,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_timeout
);

  localparam int unsigned SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CW-1:0] HoldLast  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GapLast   = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] TmoLast   = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] LastStage = SW'(N_STAGES - 1);

  typedef enum logic [2:0] {
    StAssert,
    StWaitRdy,
    StGap,
    StRun,
    StFault
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [N_STAGES-1:0]   rstn_q, rstn_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;

  logic                  rdy_cur;
  logic [CW-1:0]         cnt_inc;

  assign rdy_cur = i_ready[stage_q];
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    rstn_d    = rstn_q;
    busy_d    = busy_q;
    done_d    = done_q;
    timeout_d = timeout_q;

    // A soft request takes the same path as the hard reset; while it stays high the
    // counter is pinned at 0, which stretches the hold.
    if (!i_rstn || i_req) begin
      state_d   = StAssert;
      cnt_d     = '0;
      stage_d   = '0;
      rstn_d    = '0;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StAssert: begin
          if (i_enb) begin
            if (cnt_q == HoldLast) begin
              rstn_d  = N_STAGES'(1);
              cnt_d   = '0;
              state_d = StWaitRdy;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        StWaitRdy: begin
          // Ready wins over a timeout landing on the same edge.
          if (rdy_cur) begin
            if (stage_q == LastStage) begin
              state_d = StRun;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = StGap;
              cnt_d   = '0;
            end
          end else if (i_enb) begin
            if (cnt_q == TmoLast) begin
              state_d   = StFault;
              timeout_d = 1'b1;
              busy_d    = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        StGap: begin
          if (i_enb) begin
            if (cnt_q == GapLast) begin
              stage_d = stage_q + SW'(1);
              // Shifting in a 1 releases the next stage and keeps the thermometer shape.
              rstn_d  = (rstn_q << 1) | N_STAGES'(1);
              cnt_d   = '0;
              state_d = StWaitRdy;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        StRun, StFault: begin
          // Terminal until i_req or i_rstn.
        end

        default: begin
          state_d   = StAssert;
          cnt_d     = '0;
          stage_d   = '0;
          rstn_d    = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      endcase
    end
  end

  // Reset is synchronous and folded into the next-state logic above.
  always_ff @(posedge i_clk) begin
    state_q   <= state_d;
    cnt_q     <= cnt_d;
    stage_q   <= stage_d;
    rstn_q    <= rstn_d;
    busy_q    <= busy_d;
    done_q    <= done_d;
    timeout_q <= timeout_d;
  end

  assign o_rstn    = rstn_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer with N_STAGES=3, HOLD_CYCLES=4, STAGE_DELAY=2, TIMEOUT=8.
// Each scenario starts with one i_rstn=0 edge (edge 0), then drives edges 1..n.
// Expected checkpoints come from a table; they are queued when a scenario starts and
// popped/compared when the bench reaches the matching edge.
module tb_reset_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_enb;
  logic       i_req;
  logic [2:0] i_ready;
  logic [2:0] o_rstn;
  logic       o_busy;
  logic       o_done;
  logic       o_timeout;

  always #5 i_clk = ~i_clk;

  reset_sequencer #(
    .N_STAGES   (3),
    .HOLD_CYCLES(4),
    .STAGE_DELAY(2),
    .TIMEOUT    (8),
    .CW         (10)
  ) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_enb    (i_enb),
    .i_req    (i_req),
    .i_ready  (i_ready),
    .o_rstn   (o_rstn),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_timeout(o_timeout)
  );

  typedef struct {
    int         kind;
    int         edge_n;
    logic [2:0] rstn;
    logic       busy;
    logic       done;
    logic       tmo;
  } chk_t;

  typedef struct {
    string      name;
    int         n_edges;
    bit         toggle;
    logic [2:0] rdy;
    int         req_s;
    int         req_len;
  } scn_t;

  chk_t tbl[$];
  chk_t sb[$];
  scn_t scn[1:5];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input int k, input int e, input logic [2:0] r, input logic b,
                     input logic d, input logic t);
    chk_t c;
    c.kind = k; c.edge_n = e; c.rstn = r; c.busy = b; c.done = d; c.tmo = t;
    tbl.push_back(c);
  endtask

  // Advance one edge, sample 1 time unit later, compare any checkpoints due at this edge.
  task automatic step(input string nm, input int e);
    chk_t c;
    @(posedge i_clk);
    #1;
    while (sb.size() > 0 && sb[0].edge_n == e) begin
      c = sb.pop_front();
      n_cmp++;
      if (o_rstn !== c.rstn || o_busy !== c.busy || o_done !== c.done || o_timeout !== c.tmo)
      begin
        n_bad++;
        $display("FAIL %s edge %0d: got rstn=%b busy=%b done=%b timeout=%b, want rstn=%b busy=%b done=%b timeout=%b",
                 nm, e, o_rstn, o_busy, o_done, o_timeout, c.rstn, c.busy, c.done, c.tmo);
      end
    end
  endtask

  task automatic run(input int k);
    chk_t r;
    scn_t s;
    s = scn[k];
    r.kind = k; r.edge_n = 0; r.rstn = 3'b000; r.busy = 1'b1; r.done = 1'b0; r.tmo = 1'b0;
    sb.push_back(r);
    foreach (tbl[i]) if (tbl[i].kind == k) sb.push_back(tbl[i]);
    // Reset edge, entered from whatever state the previous scenario left behind.
    i_rstn = 1'b0; i_req = 1'b0; i_enb = 1'b1; i_ready = s.rdy;
    step(s.name, 0);
    for (int e = 1; e <= s.n_edges; e++) begin
      i_rstn  = 1'b1;
      i_enb   = s.toggle ? ((e % 2) == 1) : 1'b1;
      i_ready = s.rdy;
      i_req   = (e >= s.req_s) && (e < s.req_s + s.req_len);
      step(s.name, e);
    end
    while (sb.size() > 0) begin
      r = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s edge %0d: checkpoint never reached", s.name, r.edge_n);
    end
  endtask

  initial begin
    i_rstn = 1'b0; i_req = 1'b0; i_enb = 1'b0; i_ready = 3'b000;

    scn[1] = '{"nominal",        12, 1'b0, 3'b111, 0,  0};
    scn[2] = '{"enb_toggle",     17, 1'b1, 3'b111, 0,  0};
    scn[3] = '{"timeout",        17, 1'b0, 3'b101, 0,  0};
    scn[4] = '{"req_in_gap",     18, 1'b0, 3'b111, 6,  1};
    scn[5] = '{"req_held_run",   27, 1'b0, 3'b111, 13, 10};

    // Nominal: releases after edges 4, 7, 10; done after 11.
    add(1, 3,  3'b000, 1, 0, 0);
    add(1, 4,  3'b001, 1, 0, 0);
    add(1, 6,  3'b001, 1, 0, 0);
    add(1, 7,  3'b011, 1, 0, 0);
    add(1, 9,  3'b011, 1, 0, 0);
    add(1, 10, 3'b111, 1, 0, 0);
    add(1, 11, 3'b111, 0, 1, 0);
    // Enable on odd edges only: enabled ticks 1,3,5,7.
    add(2, 6,  3'b000, 1, 0, 0);
    add(2, 7,  3'b001, 1, 0, 0);
    add(2, 10, 3'b001, 1, 0, 0);
    add(2, 11, 3'b011, 1, 0, 0);
    add(2, 14, 3'b011, 1, 0, 0);
    add(2, 15, 3'b111, 1, 0, 0);
    add(2, 16, 3'b111, 0, 1, 0);
    // Stage 1 never ready; stage 2's ready bit must be ignored. Waiting edges 8..15.
    add(3, 4,  3'b001, 1, 0, 0);
    add(3, 7,  3'b011, 1, 0, 0);
    add(3, 14, 3'b011, 1, 0, 0);
    add(3, 15, 3'b011, 0, 0, 1);
    add(3, 16, 3'b011, 0, 0, 1);
    // One-cycle request at edge 6 while in the gap.
    add(4, 5,  3'b001, 1, 0, 0);
    add(4, 6,  3'b000, 1, 0, 0);
    add(4, 9,  3'b000, 1, 0, 0);
    add(4, 10, 3'b001, 1, 0, 0);
    add(4, 13, 3'b011, 1, 0, 0);
    add(4, 16, 3'b111, 1, 0, 0);
    add(4, 17, 3'b111, 0, 1, 0);
    // Request held for edges 13..22 from RUN; stage 0 re-releases at edge 26.
    add(5, 11, 3'b111, 0, 1, 0);
    add(5, 12, 3'b111, 0, 1, 0);
    add(5, 13, 3'b000, 1, 0, 0);
    add(5, 17, 3'b000, 1, 0, 0);
    add(5, 22, 3'b000, 1, 0, 0);
    add(5, 25, 3'b000, 1, 0, 0);
    add(5, 26, 3'b001, 1, 0, 0);

    // Order matters: the timeout run is reset out of RUN, and the repeat of the nominal
    // run is reset out of FAULT.
    run(1);
    run(3);
    run(1);
    run(2);
    run(4);
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
